// File: rtl/gcm_aes_stream_ctrl.sv
// Streams key, IV, runtime-length AAD and message blocks into a GCM-AES core and forwards its results and tag.
// Optional TAG_CHECK_EN adds exp_tag/tag_ok comparison of the returned tag.
module gcm_aes_stream_ctrl #(
    parameter int LEN_W = 16,
    parameter int TMO_W = 12
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic [127:0]     key,
    input  logic [127:0]     iv,
    input  logic [LEN_W-1:0] aad_len,
    input  logic [LEN_W-1:0] msg_len,
`ifdef TAG_CHECK_EN
    input  logic [127:0]     exp_tag,
    output logic             tag_ok,
`endif
    input  logic [127:0]     s_data,
    input  logic             s_vld,
    output logic             s_rdy,
    output logic [127:0]     dii_data,
    output logic [3:0]       dii_data_size,
    output logic             dii_data_vld,
    output logic             dii_data_type,
    output logic             dii_last_word,
    output logic [127:0]     cii_K,
    output logic             cii_ctl_vld,
    output logic             cii_IV_vld,
    input  logic             dii_data_not_ready,
    input  logic [127:0]     Out_data,
    input  logic             Out_vld,
    input  logic             Tag_vld,
    input  logic [3:0]       Out_data_size,
    input  logic             Out_last_word,
    output logic [127:0]     m_data,
    output logic [3:0]       m_size,
    output logic             m_vld,
    output logic             m_last,
    output logic [127:0]     tag_out,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int BW = LEN_W - 3;

    typedef enum logic [3:0] {
        S_IDLE, S_KEY, S_IV, S_AAD, S_AAD_GAP, S_MSG, S_MSG_GAP, S_TAG_WAIT, S_DONE
    } state_t;

    state_t           state, state_nx;
    logic [127:0]     key_q, iv_q;
    logic [LEN_W-1:0] aad_len_q, msg_len_q;
    logic [BW-1:0]    rem;
    logic [TMO_W-1:0] wd_cnt;
    logic             consume, final_blk, tag_hit, wd_expire, zero_req;
    logic [3:0]       tail_size;
`ifdef TAG_CHECK_EN
    logic [127:0]     exp_q;
`endif

    function automatic logic [BW-1:0] nblk(input logic [LEN_W-1:0] len);
        logic [LEN_W:0] sum;
        sum = {1'b0, len} + (LEN_W+1)'(15);
        return sum[LEN_W:4];
    endfunction

    assign consume   = (state == S_AAD || state == S_MSG) && s_vld && !dii_data_not_ready;
    assign final_blk = (rem == BW'(1));
    assign tail_size = ((state == S_AAD) ? aad_len_q[3:0] : msg_len_q[3:0]) - 4'd1;
    assign tag_hit   = Out_vld && Tag_vld;
    // The timeout fires on the (2^TMO_W-1)th cycle spent in TAG_WAIT.
    assign wd_expire = (wd_cnt == {{(TMO_W-1){1'b1}}, 1'b0});
    assign zero_req  = (aad_len == '0) && (msg_len == '0);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_nx      = state;
        s_rdy         = 1'b0;
        dii_data      = '0;
        dii_data_size = '0;
        dii_data_vld  = 1'b0;
        dii_data_type = 1'b0;
        dii_last_word = 1'b0;
        cii_K         = '0;
        cii_ctl_vld   = 1'b0;
        cii_IV_vld    = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state)
            S_IDLE: if (start && !zero_req) state_nx = S_KEY;
            S_KEY: begin
                busy        = 1'b1;
                cii_ctl_vld = 1'b1;
                cii_K       = key_q;
                state_nx    = S_IV;
            end
            S_IV: begin
                busy       = 1'b1;
                cii_IV_vld = 1'b1;
                dii_data   = iv_q;
                if (!dii_data_not_ready) state_nx = (aad_len_q != '0) ? S_AAD : S_MSG;
            end
            S_AAD, S_MSG: begin
                busy = 1'b1;
                if (consume) begin
                    s_rdy         = 1'b1;
                    dii_data_vld  = 1'b1;
                    dii_data      = s_data;
                    dii_data_type = (state == S_AAD);
                    dii_data_size = final_blk ? tail_size : 4'hf;
                    dii_last_word = final_blk && (state == S_MSG || msg_len_q == '0);
                    state_nx      = (state == S_AAD) ? S_AAD_GAP : S_MSG_GAP;
                end
            end
            S_AAD_GAP: begin
                busy = 1'b1;
                if (rem != '0)            state_nx = S_AAD;
                else if (msg_len_q != '0) state_nx = S_MSG;
                else                      state_nx = S_TAG_WAIT;
            end
            S_MSG_GAP: begin
                busy     = 1'b1;
                state_nx = (rem != '0) ? S_MSG : S_TAG_WAIT;
            end
            S_TAG_WAIT: begin
                busy = 1'b1;
                if (tag_hit)        state_nx = S_DONE;
                else if (wd_expire) state_nx = S_IDLE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!clrn) begin
            // NOTE: key/IV holding registers are reset too, since they drive core-facing outputs.
            state     <= S_IDLE;
            key_q     <= '0;
            iv_q      <= '0;
            aad_len_q <= '0;
            msg_len_q <= '0;
            rem       <= '0;
            wd_cnt    <= '0;
            tag_out   <= '0;
            m_data    <= '0;
            m_size    <= '0;
            m_vld     <= 1'b0;
            m_last    <= 1'b0;
            error     <= 1'b0;
`ifdef TAG_CHECK_EN
            exp_q     <= '0;
            tag_ok    <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            error <= 1'b0;

            if (state == S_IDLE && start) begin
                if (zero_req) begin
                    error <= 1'b1;
                end else begin
                    key_q     <= key;
                    iv_q      <= iv;
                    aad_len_q <= aad_len;
                    msg_len_q <= msg_len;
                    tag_out   <= '0;
`ifdef TAG_CHECK_EN
                    exp_q     <= exp_tag;
                    tag_ok    <= 1'b0;
`endif
                end
            end

            if (state == S_IV && state_nx == S_AAD)
                rem <= nblk(aad_len_q);
            else if (state_nx == S_MSG && (state == S_IV || state == S_AAD_GAP))
                rem <= nblk(msg_len_q);
            else if (consume)
                rem <= rem - BW'(1);

            wd_cnt <= (state == S_TAG_WAIT) ? wd_cnt + TMO_W'(1) : '0;

            if (state == S_TAG_WAIT) begin
                if (tag_hit) begin
                    tag_out <= Out_data;
`ifdef TAG_CHECK_EN
                    tag_ok  <= (Out_data == exp_q);
                    error   <= (Out_data != exp_q);
`endif
                end else if (wd_expire) begin
                    error <= 1'b1;
                end
            end

            m_vld  <= Out_vld && !Tag_vld;
            m_last <= Out_vld && !Tag_vld && Out_last_word;
            if (Out_vld && !Tag_vld) begin
                m_data <= Out_data;
                m_size <= Out_data_size;
            end
        end
    end

endmodule
